// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-stage control bundle for the forwarding/hazard unit.
// The master side is the decode stage and the slave side is the hazard unit.
interface fwd_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [31:0]            OPCodeIn;
  logic                   Reg2Loc;
  logic [1:0]             ALUSrc;
  logic                   RegWriteIn;
  logic                   Mem2RegIn;
  logic                   NOOPIn;
  logic                   flush;
  logic [1:0]             ForwardMuxA;
  logic [1:0]             ForwardMuxB;
  logic                   stall;
  logic                   bubble;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output OPCodeIn, Reg2Loc, ALUSrc, RegWriteIn, Mem2RegIn, NOOPIn, flush,
    input  ForwardMuxA, ForwardMuxB, stall, bubble, stall_count
  );

  modport slave (
    input  OPCodeIn, Reg2Loc, ALUSrc, RegWriteIn, Mem2RegIn, NOOPIn, flush,
    output ForwardMuxA, ForwardMuxB, stall, bubble, stall_count
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the decode stage.
// Tracks destination registers of the EX and MEM instructions in a local shadow.
module fwd_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int ZERO_REG    = 31
) (
  input logic              clk,
  input logic              reset,
  fwd_hazard_ctrl_if.slave bus
);
  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic                   ex_v, ex_ld, mem_v;
  logic [4:0]             ex_rd, mem_rd;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [4:0]             rd, rn, rm, src_a, src_b;
  logic                   use_src, fwd_b_en, hazard, dec_wr;
  logic [1:0]             sel_a, sel_b;
  logic                   unused_opcode_bits;

  function automatic logic [1:0] fwd_sel(input logic       ev,
                                         input logic [4:0] erd,
                                         input logic       mv,
                                         input logic [4:0] mrd,
                                         input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != ZR) begin
      if (ev && erd == src)      sel = 2'b01;
      else if (mv && mrd == src) sel = 2'b10;
    end
    return sel;
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
    return (&c) ? c : c + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign rd  = bus.OPCodeIn[4:0];
  assign rn  = bus.OPCodeIn[9:5];
  assign rm  = bus.OPCodeIn[20:16];
  assign unused_opcode_bits = ^{bus.OPCodeIn[31:21], bus.OPCodeIn[15:10]};

  assign src_a    = rn;
  assign src_b    = bus.Reg2Loc ? rm : rd;
  assign use_src  = ~bus.NOOPIn;
  assign fwd_b_en = use_src && (bus.ALUSrc == 2'b00);

  // Store data (Reg2Loc=0) still needs the loaded value, so srcB counts even with an immediate.
  assign hazard = ex_ld && ex_v && !bus.flush && use_src &&
                  ((ex_rd == src_a) || (ex_rd == src_b));

  assign sel_a = fwd_sel(ex_v, ex_rd, mem_v, mem_rd, src_a);
  assign sel_b = fwd_sel(ex_v, ex_rd, mem_v, mem_rd, src_b);

  assign bus.ForwardMuxA = (hazard || !use_src)  ? 2'b00 : sel_a;
  assign bus.ForwardMuxB = (hazard || !fwd_b_en) ? 2'b00 : sel_b;
  assign bus.stall       = hazard;
  assign bus.bubble      = hazard;
  assign bus.stall_count = stall_cnt;

  assign dec_wr = bus.RegWriteIn && !bus.NOOPIn && !bus.flush && !hazard;

  // EX/MEM shadow stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v      <= 1'b0;
      ex_ld     <= 1'b0;
      ex_rd     <= 5'd0;
      mem_v     <= 1'b0;
      mem_rd    <= 5'd0;
      stall_cnt <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      ex_v   <= dec_wr && (rd != ZR);
      ex_rd  <= rd;
      ex_ld  <= bus.Mem2RegIn && dec_wr;
      if (hazard) stall_cnt <= sat_inc(stall_cnt);
    end
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl: a default-width instance plus a
// 2-bit stall-counter instance driven by the same decode stimulus.
module tb_fwd_hazard_ctrl;
  logic clk;
  logic reset;

  logic [31:0] opcode;
  logic        reg2loc;
  logic [1:0]  alusrc;
  logic        regwr, mem2reg, noop, flush;

  int n_chk;
  int n_err;

  fwd_hazard_ctrl_if #(.STALL_CNT_W(16)) bus_a ();
  fwd_hazard_ctrl_if #(.STALL_CNT_W(2))  bus_s ();

  assign bus_a.OPCodeIn   = opcode;
  assign bus_a.Reg2Loc    = reg2loc;
  assign bus_a.ALUSrc     = alusrc;
  assign bus_a.RegWriteIn = regwr;
  assign bus_a.Mem2RegIn  = mem2reg;
  assign bus_a.NOOPIn     = noop;
  assign bus_a.flush      = flush;
  assign bus_s.OPCodeIn   = opcode;
  assign bus_s.Reg2Loc    = reg2loc;
  assign bus_s.ALUSrc     = alusrc;
  assign bus_s.RegWriteIn = regwr;
  assign bus_s.Mem2RegIn  = mem2reg;
  assign bus_s.NOOPIn     = noop;
  assign bus_s.flush      = flush;

  fwd_hazard_ctrl #(.STALL_CNT_W(16), .ZERO_REG(31)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  fwd_hazard_ctrl #(.STALL_CNT_W(2), .ZERO_REG(31)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int fa, input int fb, input int st);
    check_eq({tag, ".fa"},     32'(bus_a.ForwardMuxA), 32'(fa));
    check_eq({tag, ".fb"},     32'(bus_a.ForwardMuxB), 32'(fb));
    check_eq({tag, ".stall"},  32'(bus_a.stall),       32'(st));
    check_eq({tag, ".bubble"}, 32'(bus_a.bubble),      32'(st));
  endtask

  task automatic drive(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                       input logic r2l, input logic [1:0] alu, input logic rw,
                       input logic ld, input logic nop, input logic fl);
    opcode  = {11'd0, rm, 6'd0, rn, rd};
    reg2loc = r2l;
    alusrc  = alu;
    regwr   = rw;
    mem2reg = ld;
    noop    = nop;
    flush   = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    opcode = 32'd0; reg2loc = 1'b0; alusrc = 2'b00;
    regwr = 1'b0; mem2reg = 1'b0; noop = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    drive(5'd9, 5'd9, 5'd9, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("reset", 0, 0, 0);
    check_eq("reset.count", 32'(bus_a.stall_count), 32'd0);
    tick();
    reset = 1'b1;

    // Back-to-back ALU: ADDS X5,X1,X2 then ADDS X6,X5,X3 then ADDS X7,X3,X5
    drive(5'd5, 5'd1, 5'd2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("b2b0", 0, 0, 0);
    tick();
    drive(5'd6, 5'd5, 5'd3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("b2b1", 1, 0, 0);
    tick();
    drive(5'd7, 5'd3, 5'd5, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("b2b2", 0, 2, 0);
    tick();

    // Priority: X4 written twice, then read as Rn and Rm
    drive(5'd4, 5'd1, 5'd2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd4, 5'd1, 5'd2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd8, 5'd4, 5'd4, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("prio", 1, 1, 0);
    tick();

    // Load-use: LDUR X9 then ADDS X10,X9,X1
    drive(5'd9, 5'd2, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    check_out("ld", 0, 0, 0);
    tick();
    drive(5'd10, 5'd9, 5'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("lu.stall", 0, 0, 1);
    tick();
    check_out("lu.held", 2, 0, 0);
    check_eq("lu.count", 32'(bus_a.stall_count), 32'd1);
    tick();

    // Immediate operand: Rm field matches EX but ALUSrc=10
    drive(5'd11, 5'd10, 5'd10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("imm", 1, 0, 0);
    tick();

    // XZR: write X31 then read X31
    drive(5'd31, 5'd1, 5'd2, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(5'd0, 5'd31, 5'd31, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("xzr", 0, 0, 0);
    tick();

    // Store data after load: STUR X12 uses Rd as srcB with an immediate address
    drive(5'd12, 5'd1, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd12, 5'd2, 5'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("st.stall", 0, 0, 1);
    tick();
    check_out("st.held", 0, 0, 0);
    check_eq("st.count", 32'(bus_a.stall_count), 32'd2);
    tick();

    // Flushed load leaves nothing behind
    drive(5'd13, 5'd1, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive(5'd14, 5'd13, 5'd13, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("flush.ld", 0, 0, 0);
    tick();

    // Flush on a dependent instruction suppresses the stall
    drive(5'd15, 5'd1, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd16, 5'd15, 5'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("flush.dep.stall",  32'(bus_a.stall),  32'd0);
    check_eq("flush.dep.bubble", 32'(bus_a.bubble), 32'd0);
    tick();
    drive(5'd17, 5'd15, 5'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("flush.after", 2, 0, 0);
    check_eq("flush.count", 32'(bus_a.stall_count), 32'd2);
    tick();

    // NOOP with fields matching EX
    drive(5'd17, 5'd17, 5'd17, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    check_out("noop", 0, 0, 0);
    tick();

    // Reset asserted mid-stall
    drive(5'd20, 5'd1, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(5'd21, 5'd20, 5'd20, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check_out("rst.pre", 0, 0, 1);
    check_eq("rst.pre.count", 32'(bus_a.stall_count), 32'd2);
    reset = 1'b0;
    #1;
    check_out("rst.mid", 0, 0, 0);
    check_eq("rst.mid.count", 32'(bus_a.stall_count), 32'd0);
    check_eq("rst.mid.sat",   32'(bus_s.stall_count), 32'd0);
    tick();
    reset = 1'b1;

    // Five load-use stalls: 16-bit counter reaches 5, 2-bit counter pins at 3
    for (int i = 0; i < 5; i++) begin
      drive(5'd20, 5'd1, 5'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(5'd21, 5'd20, 5'd3, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("sat.stall", 32'(bus_a.stall), 32'd1);
      tick();
      check_eq("sat.count", 32'(bus_a.stall_count), 32'(i + 1));
      check_eq("sat.small", 32'(bus_s.stall_count), 32'((i + 1 > 3) ? 3 : i + 1));
      tick();
    end
    check_eq("sat.final", 32'(bus_s.stall_count), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the register/decode stage. It produces the ForwardMuxA/ForwardMuxB selects that the decode stage's forwarding muxes consume.
- Detects load-use hazards and issues a one-cycle stall plus an EX bubble.
- Keeps its own two-deep shadow of destination-register info for the instructions in EX and MEM, fed from the same decode-stage control bits.
- Sits beside the decode stage; the stall output also gates the PC and IF/ID enables.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.
- ZERO_REG, 31, register index hardwired to zero (XZR); never a forwarding match.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- OPCodeIn  in  32  instruction in decode; Rd=[4:0], Rn=[9:5], Rm=[20:16].
- Reg2Loc  in  1  1: second read register is Rm; 0: second read register is Rd (stores/CBZ).
- ALUSrc  in  2  00 selects the register for the B operand; any other value selects an immediate.
- RegWriteIn  in  1  decode instruction writes Rd.
- Mem2RegIn  in  1  decode instruction is a load.
- NOOPIn  in  1  decode slot holds no real instruction.
- flush  in  1  branch redirect; kills the decode instruction.
- ForwardMuxA  out  2  00 regfile Da, 01 ExForward, 10 MemForward.
- ForwardMuxB  out  2  same encoding; applies to the post-ALUSrc operand.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  force the REG/EX control register to a NOP this cycle.
- stall_count  out  STALL_CNT_W  number of load-use stalls, saturating.

Behaviour:
- **Reset:** while reset is low, asynchronously:
  - ex_v = mem_v = 0, ex_ld = 0, ex_rd = mem_rd = 0, stall_count = 0.
  - Outputs ForwardMuxA/B = 00, stall = 0, bubble = 0.
- **Shadow regs:** ex_{v,rd,ld} and mem_{v,rd} update on the rising clk edge.
  - Define dec_wr = RegWriteIn & ~NOOPIn & ~flush & ~stall.
  - Edge update: mem_v←ex_v, mem_rd←ex_rd; ex_v←dec_wr, ex_rd←OPCodeIn[4:0], ex_ld←Mem2RegIn & dec_wr.
  - A write to ZERO_REG is stored with v = 0.
- **Sources** (decode instruction):
  - srcA = Rn, used when ~NOOPIn.
  - srcB = Reg2Loc ? Rm : Rd, used when ~NOOPIn.
  - srcB is forwarded only when ALUSrc==00. Otherwise ForwardMuxB = 00 so the immediate passes through.
- **Forward select** (combinational, per operand):
  - 01 if ex_v & ex_rd==src & src!=ZERO_REG.
  - else 10 if mem_v & mem_rd==src & src!=ZERO_REG.
  - else 00.
  - EX match has priority over MEM match (youngest value wins). Encoding 11 is never driven.
- **Load-use:**
  - hazard = ex_ld & ex_v & ((used srcA matches ex_rd) | (srcB used for any purpose, including store data with ALUSrc≠00, matches ex_rd)) & ~flush.
  - stall = bubble = hazard.
  - While hazard is high, ForwardMuxA/B = 00; the bubble discards the operands.
- **Stall cycle:** ex_v←0 (bubble), mem←old ex. The next cycle re-evaluates the same held instruction: the load is now in MEM, giving a MEM match → select 10 and no stall. Exactly one stall cycle per load-use.
- **stall_count:** increments on each clk edge where stall=1; saturates at all-ones (no wrap).
- **Flush:** flush=1 suppresses stall/bubble and the decode push (ex_v←0). Instructions already in EX and MEM are unaffected.
- **Simultaneous events:**
  - Same register in EX and MEM → 01.
  - srcA and srcB both hazard → still one stall cycle.
  - NOOPIn with any field values → 00/00, no stall.
- **Reset mid-stall:** on reset assertion, stall drops asynchronously and no partial count is retained.
- **WB-stage writes:** covered by the register file's write-before-read. This block tracks only EX and MEM.

Test Plan:
- **Back-to-back ALU:**
  - Cycle n: ADDS X5,X1,X2 (RegWriteIn=1).
  - Cycle n+1: ADDS X6,X5,X3 with Reg2Loc=1, ALUSrc=00.
  - Expect ForwardMuxA=01, ForwardMuxB=00, stall=0.
  - Cycle n+2: ADDS X7,X3,X5 → ForwardMuxB=10.
- **Priority:**
  - X4 written at n and again at n+1; read X4 as Rn at n+2.
  - Expect ForwardMuxA=01, not 10.
- **Load-use:**
  - LDUR X9 (Mem2RegIn=1, RegWriteIn=1), then ADDS X10,X9,X1.
  - Expect one cycle of stall=1, bubble=1, selects 00.
  - Next cycle: stall=0, ForwardMuxA=10; stall_count=1.
- **Immediate and XZR:**
  - ADDI reading X5 after a write to X5 with ALUSrc=10 → ForwardMuxB=00.
  - Write X31, then read X31 → 00/00.
- **Flush and NOOP:**
  - flush=1 on a load → the following dependent instruction sees no stall, ex_v=0.
  - NOOPIn=1 with Rn=X5 matching EX → 00.
- **Reset and saturation:**
  - Pull reset low during a stall → all outputs 0 immediately.
  - With STALL_CNT_W=2, apply 5 load-use stalls → stall_count=3.
